mem_bus_arbiter: RTL

- Owns the external multiplexed 16-bit address/data memory bus and shares it between two requesters: port 0 (CPU core load/store/fetch) and port 1 (debug/DMA master).
- Arbitrates between the two requesters and sequences each access as an address phase, then an access phase, then a completion phase.
- Generates ALE, nME, nOE, RnW and ENB.
- Honours the nWait handshake, enforces a minimum wait count and aborts accesses that stall too long.

---
 rtl/mem_bus_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the external multiplexed 16-bit address/data memory bus.
// Each access runs as an address phase, then an access phase, then a completion phase.
module mem_bus_arbiter #(
  parameter int MIN_WAIT   = 1,
  parameter int TIMEOUT    = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req0_i,
  input  logic        rnW0_i,
  input  logic [15:0] addr0_i,
  input  logic [15:0] wData0_i,
  output logic        done0_o,
  output logic        err0_o,
  input  logic        req1_i,
  input  logic        rnW1_i,
  input  logic [15:0] addr1_i,
  input  logic [15:0] wData1_i,
  output logic        done1_o,
  output logic        err1_o,
  output logic [15:0] rData_o,
  input  logic [15:0] dataIn_i,
  output logic [15:0] dataOut_o,
  output logic        ale_o,
  output logic        nMe_o,
  output logic        nOe_o,
  output logic        rnW_o,
  output logic        enb_o,
  input  logic        nWait_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam logic [7:0]  MinWaitC   = 8'(MIN_WAIT);
  localparam logic [15:0] TimeoutC   = 16'(TIMEOUT);
  localparam bit          TimeoutEn  = (TIMEOUT != 0);
  localparam bit          FixedPrioC = (FIXED_PRIO != 0);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        rrPtr_q, rrPtr_d;
  logic        rnWLat_q, rnWLat_d;
  logic [15:0] addrLat_q, addrLat_d;
  logic [15:0] wDataLat_q, wDataLat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] rData_q, rData_d;

  logic        grantWin;
  logic [15:0] stallNext;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rrPtr_q    <= 1'b0;
      rnWLat_q   <= 1'b1;
      addrLat_q  <= 16'h0000;
      wDataLat_q <= 16'h0000;
      cnt_q      <= 8'd0;
      stall_q    <= 16'd0;
      rData_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rrPtr_q    <= rrPtr_d;
      rnWLat_q   <= rnWLat_d;
      addrLat_q  <= addrLat_d;
      wDataLat_q <= wDataLat_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
      rData_q    <= rData_d;
    end
  end

  // rrPtr_q names the port that wins a tie; it always points away from the last grant.
  always_comb begin
    grantWin = 1'b0;
    if (FixedPrioC) begin
      grantWin = !req0_i;
    end else if (req0_i && req1_i) begin
      grantWin = rrPtr_q;
    end else begin
      grantWin = req1_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rrPtr_d    = rrPtr_q;
    rnWLat_d   = rnWLat_q;
    addrLat_d  = addrLat_q;
    wDataLat_d = wDataLat_q;
    cnt_d      = cnt_q;
    stall_d    = stall_q;
    rData_d    = rData_q;
    stallNext  = stall_q;
    if (!nWait_i && (stall_q != 16'hFFFF)) begin
      stallNext = stall_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          grant_d    = grantWin;
          rrPtr_d    = !grantWin;
          rnWLat_d   = grantWin ? rnW1_i   : rnW0_i;
          addrLat_d  = grantWin ? addr1_i  : addr0_i;
          wDataLat_d = grantWin ? wData1_i : wData0_i;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        cnt_d   = 8'd1;
        stall_d = 16'd0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if ((cnt_q >= MinWaitC) && nWait_i) begin
          state_d = DONE;
          if (rnWLat_q) begin
            rData_d = dataIn_i;
          end
        end else begin
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          stall_d = stallNext;
          if (TimeoutEn && (stallNext >= TimeoutC)) begin
            state_d = ERR;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and handshake outputs depend only on registered state, so they hold for the whole cycle.
  always_comb begin
    ale_o     = 1'b0;
    nMe_o     = 1'b1;
    nOe_o     = 1'b1;
    rnW_o     = 1'b1;
    enb_o     = 1'b0;
    dataOut_o = 16'h0000;
    done0_o   = 1'b0;
    done1_o   = 1'b0;
    err0_o    = 1'b0;
    err1_o    = 1'b0;

    unique case (state_q)
      ADDR: begin
        ale_o     = 1'b1;
        enb_o     = 1'b1;
        dataOut_o = addrLat_q;
      end
      ACCESS: begin
        nMe_o = 1'b0;
        rnW_o = rnWLat_q;
        if (rnWLat_q) begin
          nOe_o = 1'b0;
        end else begin
          enb_o     = 1'b1;
          dataOut_o = wDataLat_q;
        end
      end
      DONE: begin
        done0_o = !grant_q;
        done1_o = grant_q;
      end
      ERR: begin
        err0_o = !grant_q;
        err1_o = grant_q;
      end
      default: begin
      end
    endcase
  end

  assign rData_o = rData_q;

endmodule
